// File: rtl/ascii_message_sequencer.sv
// ascii_message_sequencer: steps a 16-entry writable ASCII buffer into a 7-segment decoder,
// showing each character for SHOW_TICKS step ticks followed by a one-tick blank gap.
module ascii_message_sequencer #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int STEP_HZ    = 2,
  parameter int SHOW_TICKS = 3
) (
  input  logic       clk50MHz,
  input  logic       rst_n,
  input  logic       run,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [6:0] wr_data,
  input  logic [3:0] len,
  output logic [6:0] ASCII_out,
  output logic       dp_out,
  output logic       pass_done
);
  localparam int DIV = CLK_HZ / STEP_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int CW  = $clog2(SHOW_TICKS + 1);
  typedef enum logic [1:0] {IDLE, SHOW, GAP, PAUSE} state_t;
  state_t state_q, state_d, saved_q, saved_d, eff;
  logic [PW-1:0] pre_q, pre_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d, len_q, len_d;
  logic [6:0] buf_q [16];
  logic [6:0] buf_d [16];
  logic [6:0] ascii_q, ascii_d;
  logic dp_q, dp_d, pd_q, pd_d, active, tick, wrap;
  always_comb begin
    buf_d = buf_q;
    if (wr_en) buf_d[wr_addr] = wr_data;
    // the prescaler is parked at 0 in IDLE so the first character gets a full show time
    active = run && (state_q != IDLE);
    tick = active && (pre_q == PW'(DIV - 1));
    pre_d = active ? (tick ? '0 : pre_q + 1'b1) : pre_q;
    eff = (state_q == PAUSE) ? saved_q : state_q;
    wrap = idx_q == len_q;
    state_d = state_q;
    saved_d = saved_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    len_d = len_q;
    ascii_d = ascii_q;
    dp_d = dp_q;
    pd_d = 1'b0;
    if (state_q == IDLE) begin
      if (run) begin
        len_d = len;
        idx_d = '0;
        ascii_d = buf_q[0];
        dp_d = len == 4'd0;
        state_d = SHOW;
      end
    end else if (!run) begin
      state_d = PAUSE;
      saved_d = eff;
    end else begin
      // resuming from PAUSE acts on the saved state in the same cycle, so a pause costs exactly its length
      state_d = eff;
      if (tick && eff == SHOW) begin
        if (cnt_q == CW'(SHOW_TICKS - 1)) begin
          cnt_d = '0;
          state_d = GAP;
          ascii_d = 7'h20;
          dp_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (tick) begin
        idx_d = wrap ? 4'd0 : idx_q + 4'd1;
        len_d = wrap ? len : len_q;
        pd_d = wrap;
        ascii_d = buf_q[idx_d];
        dp_d = idx_d == len_d;
        state_d = SHOW;
      end
    end
  end
  always_ff @(posedge clk50MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      saved_q <= SHOW;
      pre_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      len_q <= '0;
      for (int i = 0; i < 16; i++) buf_q[i] <= 7'h20;
      ascii_q <= 7'h20;
      dp_q <= 1'b0;
      pd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      len_q <= len_d;
      buf_q <= buf_d;
      ascii_q <= ascii_d;
      dp_q <= dp_d;
      pd_q <= pd_d;
    end
  end
  assign ASCII_out = ascii_q;
  assign dp_out = dp_q;
  assign pass_done = pd_q;
endmodule

// File: tb/tb_ascii_message_sequencer.sv
// tb_ascii_message_sequencer: directed scenarios with hand-derived cycle-by-cycle output patterns.
// Sample s0 is the first falling edge after the rising edge that sees run=1.
module tb_ascii_message_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  logic wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [6:0] wr_data = '0;
  logic [3:0] len = '0;
  logic [6:0] ascii;
  logic dp, pd;
  int checks = 0;
  int fails = 0;
  ascii_message_sequencer #(.CLK_HZ(8), .STEP_HZ(2), .SHOW_TICKS(2)) dut (
    .clk50MHz(clk), .rst_n(rst_n), .run(run), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .len(len), .ASCII_out(ascii), .dp_out(dp), .pass_done(pd)
  );
  always #5 clk = ~clk;
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    run = 1'b0;
    wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic wr(input logic [3:0] a, input logic [6:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (ascii !== 7'h20) begin fails++; $display("FAIL reset ascii got %h exp 20", ascii); end
    if (dp !== 1'b0) begin fails++; $display("FAIL reset dp got %b exp 0", dp); end
    if (pd !== 1'b0) begin fails++; $display("FAIL reset pass_done got %b exp 0", pd); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_blank();
    logic [6:0] ea;
    logic ed, ep;
    do_reset();
    len = 4'd0;
    run = 1'b1;
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      ea = 7'h20;
      ed = (k % 12) < 8;
      ep = k > 0 && (k % 12) == 0;
      checks += 3;
      if (ascii !== ea) begin fails++; $display("FAIL blank ascii k=%0d got %h exp %h", k, ascii, ea); end
      if (dp !== ed) begin fails++; $display("FAIL blank dp k=%0d got %b exp %b", k, dp, ed); end
      if (pd !== ep) begin fails++; $display("FAIL blank pass_done k=%0d got %b exp %b", k, pd, ep); end
    end
  endtask
  task automatic test_hi();
    logic [6:0] ea;
    logic ed, ep;
    int p;
    do_reset();
    wr(4'd0, 7'h48);
    wr(4'd1, 7'h49);
    len = 4'd1;
    run = 1'b1;
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      p = k % 24;
      ea = p < 8 ? 7'h48 : p < 12 ? 7'h20 : p < 20 ? 7'h49 : 7'h20;
      ed = p >= 12 && p < 20;
      ep = k > 0 && p == 0;
      checks += 3;
      if (ascii !== ea) begin fails++; $display("FAIL hi ascii k=%0d got %h exp %h", k, ascii, ea); end
      if (dp !== ed) begin fails++; $display("FAIL hi dp k=%0d got %b exp %b", k, dp, ed); end
      if (pd !== ep) begin fails++; $display("FAIL hi pass_done k=%0d got %b exp %b", k, pd, ep); end
    end
  endtask
  task automatic test_pause();
    logic [6:0] ea;
    logic ed, ep;
    int p;
    do_reset();
    wr(4'd0, 7'h48);
    wr(4'd1, 7'h49);
    len = 4'd1;
    run = 1'b1;
    for (int k = 0; k < 44; k++) begin
      @(negedge clk);
      if (k >= 14 && k < 17) begin
        ea = 7'h49;
        ed = 1'b1;
        ep = 1'b0;
      end else begin
        p = (k < 14 ? k : k - 3) % 24;
        ea = p < 8 ? 7'h48 : p < 12 ? 7'h20 : p < 20 ? 7'h49 : 7'h20;
        ed = p >= 12 && p < 20;
        ep = k > 0 && p == 0;
      end
      checks += 3;
      if (ascii !== ea) begin fails++; $display("FAIL pause ascii k=%0d got %h exp %h", k, ascii, ea); end
      if (dp !== ed) begin fails++; $display("FAIL pause dp k=%0d got %b exp %b", k, dp, ed); end
      if (pd !== ep) begin fails++; $display("FAIL pause pass_done k=%0d got %b exp %b", k, pd, ep); end
      if (k == 13) run = 1'b0;
      if (k == 16) run = 1'b1;
    end
  endtask
  task automatic test_write_shown();
    logic [6:0] ea;
    logic ed, ep;
    int p;
    do_reset();
    wr(4'd0, 7'h48);
    wr(4'd1, 7'h49);
    len = 4'd1;
    run = 1'b1;
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      p = k % 24;
      ea = p < 8 ? 7'h48 : p < 12 ? 7'h20 : p < 20 ? (k < 24 ? 7'h49 : 7'h4F) : 7'h20;
      ed = p >= 12 && p < 20;
      ep = k > 0 && p == 0;
      checks += 3;
      if (ascii !== ea) begin fails++; $display("FAIL wrshown ascii k=%0d got %h exp %h", k, ascii, ea); end
      if (dp !== ed) begin fails++; $display("FAIL wrshown dp k=%0d got %b exp %b", k, dp, ed); end
      if (pd !== ep) begin fails++; $display("FAIL wrshown pass_done k=%0d got %b exp %b", k, pd, ep); end
      if (k == 13) begin wr_en = 1'b1; wr_addr = 4'd1; wr_data = 7'h4F; end
      if (k == 14) wr_en = 1'b0;
    end
  endtask
  task automatic test_len_change();
    logic [6:0] ea;
    logic ed, ep;
    int p;
    do_reset();
    wr(4'd0, 7'h48);
    wr(4'd1, 7'h49);
    len = 4'd1;
    run = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (k < 24) begin
        ea = k < 8 ? 7'h48 : k < 12 ? 7'h20 : k < 20 ? 7'h49 : 7'h20;
        ed = k >= 12 && k < 20;
        ep = 1'b0;
      end else begin
        p = (k - 24) % 12;
        ea = p < 8 ? 7'h48 : 7'h20;
        ed = p < 8;
        ep = p == 0;
      end
      checks += 3;
      if (ascii !== ea) begin fails++; $display("FAIL lenchg ascii k=%0d got %h exp %h", k, ascii, ea); end
      if (dp !== ed) begin fails++; $display("FAIL lenchg dp k=%0d got %b exp %b", k, dp, ed); end
      if (pd !== ep) begin fails++; $display("FAIL lenchg pass_done k=%0d got %b exp %b", k, pd, ep); end
      if (k == 2) len = 4'd0;
    end
  endtask
  task automatic test_reset_mid();
    logic [6:0] ea;
    logic ed;
    do_reset();
    wr(4'd0, 7'h48);
    wr(4'd1, 7'h49);
    len = 4'd1;
    run = 1'b1;
    for (int k = 0; k < 15; k++) @(negedge clk);
    checks += 2;
    if (ascii !== 7'h49) begin fails++; $display("FAIL rstmid pre ascii got %h exp 49", ascii); end
    if (dp !== 1'b1) begin fails++; $display("FAIL rstmid pre dp got %b exp 1", dp); end
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (ascii !== 7'h20) begin fails++; $display("FAIL rstmid ascii got %h exp 20", ascii); end
    if (dp !== 1'b0) begin fails++; $display("FAIL rstmid dp got %b exp 0", dp); end
    if (pd !== 1'b0) begin fails++; $display("FAIL rstmid pass_done got %b exp 0", pd); end
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks += 3;
      if (ascii !== 7'h20) begin fails++; $display("FAIL rstmid idle ascii k=%0d got %h exp 20", k, ascii); end
      if (dp !== 1'b0) begin fails++; $display("FAIL rstmid idle dp k=%0d got %b exp 0", k, dp); end
      if (pd !== 1'b0) begin fails++; $display("FAIL rstmid idle pass_done k=%0d got %b exp 0", k, pd); end
    end
    run = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      ea = 7'h20;
      ed = k >= 12 && k < 20;
      checks += 3;
      if (ascii !== ea) begin fails++; $display("FAIL rstmid cleared ascii k=%0d got %h exp %h", k, ascii, ea); end
      if (dp !== ed) begin fails++; $display("FAIL rstmid cleared dp k=%0d got %b exp %b", k, dp, ed); end
      if (pd !== 1'b0) begin fails++; $display("FAIL rstmid cleared pass_done k=%0d got %b exp 0", k, pd); end
    end
  endtask
  initial begin
    test_reset();
    test_blank();
    test_hi();
    test_pause();
    test_write_shown();
    test_len_change();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/ascii_message_sequencer.md
ASCII_MESSAGE_SEQUENCER -- requirements
Module: ascii_message_sequencer

Sits directly upstream of the one-digit ASCII 7-segment decoder. It replaces the free-running 7-bit counter with a writable message buffer that is stepped one character at a time.

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000: input clock frequency in Hz.
REQ-002 Parameter STEP_HZ, default 2: character step rate in Hz; CLK_HZ/STEP_HZ SHALL be an integer >= 2.
REQ-003 Parameter SHOW_TICKS, default 3: number of step ticks each character is shown, >= 1.
REQ-004 Port clk50MHz, input, 1 bit: the only clock; all logic is on the rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port run, input, 1 bit: level; 1 = sequence, 0 = hold/pause.
REQ-007 Port wr_en, input, 1 bit: buffer write strobe, sampled each clock.
REQ-008 Port wr_addr, input, 4 bits: buffer write address, 0..15.
REQ-009 Port wr_data, input, 7 bits: ASCII code to write.
REQ-010 Port len, input, 4 bits: message length minus 1 (0 means 1 character, 15 means 16 characters).
REQ-011 Port ASCII_out, output, 7 bits: code to the decoder; registered.
REQ-012 Port dp_out, output, 1 bit: 1 while the last message character is shown; registered.
REQ-013 Port pass_done, output, 1 bit: one-cycle pulse at the end of each full message pass.

Function
REQ-014 The prescaler SHALL count 0..CLK_HZ/STEP_HZ-1 and wrap; the internal tick SHALL be high for exactly one cycle at the wrap.
REQ-015 The prescaler SHALL advance only while run=1, and SHALL hold its count while run=0.
REQ-016 The buffer SHALL be 16 x 7 bits; when wr_en=1, buf[wr_addr] SHALL take wr_data at the next edge, in any state.
REQ-017 The FSM SHALL have four states: IDLE, SHOW, GAP, PAUSE.
REQ-018 IDLE, run=1: latch len into len_q, set idx=0, load ASCII_out=buf[0], and go to SHOW on the same edge.
REQ-019 SHOW: count ticks; on the SHOW_TICKS-th tick, go to GAP and drive ASCII_out=7'h20 (space) and dp_out=0.
REQ-020 GAP: on the next tick, if idx==len_q, pulse pass_done, set idx=0, re-latch len and go to SHOW; otherwise idx=idx+1 and go to SHOW. In both cases load ASCII_out=buf[new idx].
REQ-021 dp_out SHALL be driven to (new idx==len_q) on every load into SHOW.
REQ-022 ASCII_out SHALL be captured from the buffer only on entry to SHOW; a write to the index currently shown SHALL NOT alter ASCII_out until that index is loaded again.
REQ-023 run=0 in SHOW or GAP: go to PAUSE, hold ASCII_out, dp_out, idx and the tick count; run=1 in PAUSE: return to the saved state and resume counting.
REQ-024 A len change mid-pass SHALL take effect only at the wrap or on leaving IDLE.
REQ-025 A write and a load of the same address in the same cycle SHALL load the old buffer value.
REQ-026 idx SHALL be 4 bits and wrap explicitly at len_q; it SHALL never exceed len_q.

Reset
REQ-027 rst_n=0 SHALL immediately set: state=IDLE, idx=0, prescaler=0, tick count=0, len_q=0, every buf entry=7'h20, ASCII_out=7'h20, dp_out=0, pass_done=0.
REQ-028 Reset asserted mid-pass SHALL abort the pass with no pass_done pulse; after release the block waits in IDLE for run=1.

Verification
All scenarios use CLK_HZ=8, STEP_HZ=2 (tick every 4 cycles) and SHOW_TICKS=2.
REQ-029 Reset, then run=1 with no writes -> ASCII_out=7'h20 throughout, dp_out=1 (len=0), pass_done pulses every 12 cycles.
REQ-030 Write "HI" (0x48, 0x49), len=1, run=1 -> sequence 0x48 for 8 cycles, 0x20 for 4 cycles, 0x49 with dp_out=1 for 8 cycles, 0x20 for 4 cycles, a pass_done pulse, then repeat.
REQ-031 run=0 midway through showing 0x49 for 3 cycles -> output frozen; after run=1 the remaining show time is unchanged (pause adds exactly 3 cycles).
REQ-032 Write buf[1]=0x4F while 0x49 is shown -> 0x49 persists; the next pass shows 0x4F.
REQ-033 Change len from 1 to 0 during the first character -> the current pass completes both characters, and subsequent passes show only buf[0] with dp_out=1.
REQ-034 rst_n pulse while 0x49 is shown -> ASCII_out=0x20 and dp_out=0 within the reset, no pass_done, buffer cleared to spaces.
